// File: rtl/processor_pkg.sv
// Shared RV32I execute-stage definitions: ALU operation codes, datapath widths
// and the bit-reversal helper used by the shifter.
package processor_pkg;

  localparam int XLEN   = 32;
  localparam int SHAMTW = 5;

  // Full ALU code space; alu_core_reg implements ADD..SRL and treats the rest as illegal.
  typedef enum logic [4:0] {
    ALU_NONE  = 5'd0,
    ALU_ADD   = 5'd1,
    ALU_SUB   = 5'd2,
    ALU_XOR   = 5'd3,
    ALU_OR    = 5'd4,
    ALU_AND   = 5'd5,
    ALU_SLL   = 5'd6,
    ALU_SRL   = 5'd7,
    ALU_SRA   = 5'd8,
    ALU_SLT   = 5'd9,
    ALU_SLTU  = 5'd10,
    ALU_IMM   = 5'd11,
    ALU_LUI   = 5'd12,
    ALU_AUIPC = 5'd13
  } alu_op_e;

  typedef enum logic {
    SHIFT_LEFT  = 1'b0,
    SHIFT_RIGHT = 1'b1
  } shift_dir_e;

  function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) begin
      r[i] = v[XLEN-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_core_reg_if.sv
// Operand/result bundle between the ALU wrapper (master) and alu_core_reg (slave).
interface alu_core_reg_if;
  import processor_pkg::*;

  // Handshake: a beat is accepted on every rising edge where in_valid is high
  // (there is no ready; the core never stalls). out_valid marks rd_write_val as
  // the result of the beat accepted on the previous edge.
  logic            in_valid;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      alu_control;
  logic            out_valid;
  logic [XLEN-1:0] rd_write_val;

  modport master (
    output in_valid, rs1_val, rs2_val, alu_control,
    input  out_valid, rd_write_val
  );

  modport slave (
    input  in_valid, rs1_val, rs2_val, alu_control,
    output out_valid, rd_write_val
  );

endinterface

// File: rtl/alu_shifter.sv
// Logarithmic barrel shifter; right shifts reuse the left-shift stages by
// reversing the data on the way in and out.
module alu_shifter
  import processor_pkg::*;
(
  input  logic [XLEN-1:0]   data,
  input  logic [SHAMTW-1:0] shamt,
  input  shift_dir_e        dir,
  output logic [XLEN-1:0]   result
);

  logic [XLEN-1:0] stage [SHAMTW+1];

  always_comb begin
    stage[0] = (dir == SHIFT_RIGHT) ? bit_reverse(data) : data;
    for (int i = 0; i < SHAMTW; i++) begin
      stage[i+1] = shamt[i] ? (stage[i] << (1 << i)) : stage[i];
    end
    result = (dir == SHIFT_RIGHT) ? bit_reverse(stage[SHAMTW]) : stage[SHAMTW];
  end

endmodule

// File: rtl/alu_core_reg.sv
// Integer ALU core (ADD/SUB/XOR/OR/AND/SLL/SRL) with a registered result,
// one cycle of latency and a new operation accepted every cycle.
module alu_core_reg
  import processor_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  alu_core_reg_if.slave bus
);

  alu_op_e         op;
  logic            is_sub;
  logic [XLEN-1:0] addend;
  logic [XLEN-1:0] sum;
  shift_dir_e      shift_dir;
  logic [XLEN-1:0] shift_res;
  logic [XLEN-1:0] result;

  logic            out_valid_d, out_valid_q;
  logic [XLEN-1:0] rd_write_val_d, rd_write_val_q;

  // SUB shares the adder as rs1 + ~rs2 + 1; the carry out is dropped.
  always_comb begin
    op        = alu_op_e'(bus.alu_control);
    is_sub    = (op == ALU_SUB);
    addend    = is_sub ? ~bus.rs2_val : bus.rs2_val;
    sum       = bus.rs1_val + addend + XLEN'(is_sub);
    shift_dir = (op == ALU_SRL) ? SHIFT_RIGHT : SHIFT_LEFT;
  end

  alu_shifter u_shifter (
    .data   (bus.rs1_val),
    .shamt  (bus.rs2_val[SHAMTW-1:0]),
    .dir    (shift_dir),
    .result (shift_res)
  );

  // Codes outside ADD..SRL, including ones the wrapper handles, yield zero.
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD, ALU_SUB: result = sum;
      ALU_XOR:          result = bus.rs1_val ^ bus.rs2_val;
      ALU_OR:           result = bus.rs1_val | bus.rs2_val;
      ALU_AND:          result = bus.rs1_val & bus.rs2_val;
      ALU_SLL, ALU_SRL: result = shift_res;
      default:          result = '0;
    endcase
  end

  always_comb begin
    out_valid_d    = bus.in_valid;
    rd_write_val_d = bus.in_valid ? result : rd_write_val_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      rd_write_val_q <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      rd_write_val_q <= rd_write_val_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.rd_write_val = rd_write_val_q;

endmodule

// File: tb/tb_alu_core_reg.sv
// Directed and randomized checks of alu_core_reg against an arithmetic reference model.
module tb_alu_core_reg;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic        exp_valid;
  logic [31:0] exp_val;

  alu_core_reg_if bus_if ();

  alu_core_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [4:0] code, input logic [31:0] a, b);
    case (code)
      5'd1:    return a + b;
      5'd2:    return a - b;
      5'd3:    return a ^ b;
      5'd4:    return a | b;
      5'd5:    return a & b;
      5'd6:    return a << b[4:0];
      5'd7:    return a >> b[4:0];
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge pass, then compare the outputs.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
    rst                = r;
    bus_if.in_valid    = v;
    bus_if.alu_control = code;
    bus_if.rs1_val     = a;
    bus_if.rs2_val     = b;
    @(negedge clk);
    if (r) begin
      exp_valid = 1'b0;
      exp_val   = 32'h0;
    end else if (v) begin
      exp_valid = 1'b1;
      exp_val   = ref_alu(code, a, b);
    end else begin
      exp_valid = 1'b0;
    end
    check({tag, ".valid"}, {31'b0, bus_if.out_valid}, {31'b0, exp_valid});
    check({tag, ".data"}, bus_if.rd_write_val, exp_val);
  endtask

  initial begin
    logic        r, v;
    logic [4:0]  code;
    logic [31:0] a, b;

    exp_valid = 1'b0;
    exp_val   = 32'h0;
    rst                = 1'b1;
    bus_if.in_valid    = 1'b0;
    bus_if.alu_control = 5'd0;
    bus_if.rs1_val     = 32'h0;
    bus_if.rs2_val     = 32'h0;
    @(negedge clk);

    step("reset",     1'b1, 1'b1, 5'd1, 32'h1234_5678, 32'h1);
    step("add_wrap",  1'b0, 1'b1, 5'd1, 32'hFFFF_FFFF, 32'h1);
    step("sub_neg",   1'b0, 1'b1, 5'd2, 32'd5,         32'd7);
    step("xor",       1'b0, 1'b1, 5'd3, 32'hA5A5_A5A5, 32'hFFFF_0000);
    step("or",        1'b0, 1'b1, 5'd4, 32'hF0F0_0000, 32'h0000_0F0F);
    step("and",       1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 32'hFFFF_0000);
    step("sll_hi",    1'b0, 1'b1, 5'd6, 32'h1,         32'h0000_0021);
    step("srl_31",    1'b0, 1'b1, 5'd7, 32'h8000_0000, 32'd31);
    step("sll_0",     1'b0, 1'b1, 5'd6, 32'hCAFE_F00D, 32'hFFFF_FFE0);
    step("srl_0",     1'b0, 1'b1, 5'd7, 32'hCAFE_F00D, 32'h0);
    step("sll_31",    1'b0, 1'b1, 5'd6, 32'h0000_0003, 32'd31);
    step("srl_16",    1'b0, 1'b1, 5'd7, 32'hFFFF_0000, 32'd16);
    step("ill_0",     1'b0, 1'b1, 5'd0, 32'h1111_1111, 32'h2222_2222);
    step("add_pre",   1'b0, 1'b1, 5'd1, 32'd40,        32'd2);
    step("ill_8",     1'b0, 1'b1, 5'd8, 32'h8000_0000, 32'd4);
    step("ill_31",    1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step("load",      1'b0, 1'b1, 5'd4, 32'h0000_00AA, 32'h0000_5500);
    step("idle_hold", 1'b0, 1'b0, 5'd1, 32'h7777_7777, 32'h1);
    step("idle_hold2",1'b0, 1'b0, 5'd2, 32'h0,         32'h9);
    step("b2b_a",     1'b0, 1'b1, 5'd1, 32'd100,       32'd23);
    step("b2b_b",     1'b0, 1'b1, 5'd2, 32'd100,       32'd23);
    step("mid_rst",   1'b1, 1'b1, 5'd3, 32'hFFFF_FFFF, 32'h0);
    step("post_rst",  1'b0, 1'b1, 5'd1, 32'd9,         32'd10);
    step("post_rst2", 1'b0, 1'b1, 5'd6, 32'h8000_0001, 32'd1);

    for (int i = 0; i < 10000; i++) begin
      r    = ($urandom_range(0, 99) == 0);
      v    = ($urandom_range(0, 9) != 0);
      code = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 7));
      a    = $urandom;
      b    = $urandom;
      step("rand", r, v, code, a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
